// File: rtl/sp_memory_param.sv
// Purpose : parametrised single-port scratch memory with byte-enable writes, registered read and a one-word-per-cycle clear engine.
// Latency : reads return rd_data/rd_valid one cycle after the sampling edge; writes land on the sampling edge.
// Backpr. : no flow control; while busy=1 every access is silently dropped, and err flags out-of-range addresses.
//
// Ports:
//   clk       - single clock, all logic on the rising edge
//   rst       - asynchronous, active-high reset; restarts the clear engine at index 0
//   sel, wr   - access request for this cycle; wr=1 write, wr=0 read
//   address   - word address; values >= DEPTH are rejected with an err pulse
//   wr_data   - write data
//   wr_be     - byte enables; bit k covers wr_data[8k+7:8k]
//   clear     - one-cycle request to zero the whole array (wins over a same-cycle access)
//   rd_data   - registered read data; holds its value between reads
//   rd_valid  - one-cycle strobe qualifying rd_data
//   busy      - clear engine running
//   err       - one-cycle strobe for an out-of-range access
//
// DATA_W must be a multiple of 8 and 2**ADDR_W must be >= DEPTH.
module sp_memory_param #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel,
    input  logic                  wr,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  clear,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  err
);

    localparam int NB = DATA_W / 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Depth widened by one bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;

    // Storage has no reset; only the clear engine zeroes it.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic              accept;
    logic              do_write;
    logic              do_read;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [NB-1:0]     mem_wbe;

    assign in_range = ({1'b0, address} < DEPTH_X);

    // A same-cycle clear request takes priority and drops the access.
    assign accept   = (state == ST_IDLE) && sel && !clear;
    assign do_write = accept &&  wr && in_range;
    assign do_read  = accept && !wr && in_range;

    assign busy     = (state == ST_CLEAR);

    // Single write port shared by the clear engine and user writes. While
    // rst is held the engine keeps zeroing mem[0]; that is harmless because
    // the full sweep restarts from index 0 after release.
    always_comb begin
        mem_we  = 1'b0;
        mem_wa  = address;
        mem_wd  = wr_data;
        mem_wbe = wr_be;
        if (state == ST_CLEAR) begin
            mem_we  = 1'b1;
            mem_wa  = ptr;
            mem_wd  = '0;
            mem_wbe = '1;
        end else if (do_write) begin
            mem_we  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_wbe[b]) begin
                    mem[mem_wa][8*b +: 8] <= mem_wd[8*b +: 8];
                end
            end
        end
    end

    // Control FSM, read register and status strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_CLEAR;
            ptr      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= do_read;
            err      <= accept && !in_range;

            if (do_read) begin
                rd_data <= mem[address];
            end

            if (clear) begin
                // Restart the sweep from index 0, whether idle or mid-clear.
                state <= ST_CLEAR;
                ptr   <= '0;
            end else if (state == ST_CLEAR) begin
                if (ptr == LAST_IDX) begin
                    state <= ST_IDLE;
                    ptr   <= '0;
                end else begin
                    ptr   <= ptr + ADDR_W'(1);
                end
            end
        end
    end

endmodule
